// File: rtl/s2_hazard_fwd_unit.sv
// Stage-2 operand forwarding selects and load-use stall for a 3-stage RV32I pipeline.
// Shadows the s2/s3 instructions and freezes the front end while load data is pending.
module s2_hazard_fwd_unit #(
  parameter int          LOAD_STALL_CYCLES = 1,
  parameter logic [31:0] NOP               = 32'h00000013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_s1,
  input  logic        flush,
  output logic [1:0]  rs1_sel,
  output logic [1:0]  rs2_sel,
  output logic        stall,
  output logic [31:0] instr_s2,
  output logic [31:0] instr_s3
);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_ARI_I  = 7'b0010011;
  localparam logic [6:0] OP_ARI_R  = 7'b0110011;
  localparam logic [6:0] OP_CSR    = 7'b1110011;

  localparam logic [1:0] SEL_ALU  = 2'b00;
  localparam logic [1:0] SEL_LOAD = 2'b01;
  localparam logic [1:0] SEL_RF   = 2'b10;

  localparam int CNT_W = $clog2(LOAD_STALL_CYCLES + 1) + 1;
  localparam logic [CNT_W-1:0] CNT_INIT =
    (LOAD_STALL_CYCLES > 0) ? CNT_W'(LOAD_STALL_CYCLES - 1) : '0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    GO   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             flush_pend_q;
  logic [31:0]      instr_s2_q, instr_s3_q;

  function automatic logic writes_rd(input logic [6:0] opc, input logic [4:0] rd);
    logic op_ok;
    op_ok = (opc == OP_LUI)  || (opc == OP_AUIPC) || (opc == OP_JAL) ||
            (opc == OP_JALR) || (opc == OP_LOAD)  || (opc == OP_ARI_R) ||
            (opc == OP_ARI_I);
    return op_ok && (rd != 5'd0);
  endfunction

  function automatic logic reads_rs1(input logic [6:0] opc, input logic f3_hi);
    return (opc == OP_JALR)  || (opc == OP_BRANCH) || (opc == OP_LOAD) ||
           (opc == OP_STORE) || (opc == OP_ARI_R)  || (opc == OP_ARI_I) ||
           ((opc == OP_CSR) && !f3_hi);
  endfunction

  function automatic logic reads_rs2(input logic [6:0] opc);
    return (opc == OP_ARI_R) || (opc == OP_BRANCH) || (opc == OP_STORE);
  endfunction

  logic [6:0] s2_opc, s3_opc;
  logic [4:0] s2_rs1, s2_rs2, s3_rd;
  logic       s3_wr, s3_is_load, match_1, match_2, load_hazard;

  assign s2_opc     = instr_s2_q[6:0];
  assign s2_rs1     = instr_s2_q[19:15];
  assign s2_rs2     = instr_s2_q[24:20];
  assign s3_opc     = instr_s3_q[6:0];
  assign s3_rd      = instr_s3_q[11:7];
  assign s3_wr      = writes_rd(s3_opc, s3_rd);
  assign s3_is_load = (s3_opc == OP_LOAD);

  // rd==0 is excluded by writes_rd, so x0 can never produce a match.
  assign match_1 = reads_rs1(s2_opc, instr_s2_q[14]) && s3_wr && (s3_rd == s2_rs1);
  assign match_2 = reads_rs2(s2_opc) && s3_wr && (s3_rd == s2_rs2);

  assign load_hazard = (match_1 || match_2) && s3_is_load && (LOAD_STALL_CYCLES > 0);

  assign rs1_sel = match_1 ? (s3_is_load ? SEL_LOAD : SEL_ALU) : SEL_RF;
  assign rs2_sel = match_2 ? (s3_is_load ? SEL_LOAD : SEL_ALU) : SEL_RF;

  // GO releases the freeze while the hazard is still visible, so a pair stalls once.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (load_hazard) begin
          stall   = 1'b1;
          cnt_d   = CNT_INIT;
          state_d = (LOAD_STALL_CYCLES > 1) ? WAIT : GO;
        end
      end
      WAIT: begin
        stall = 1'b1;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = GO;
        end
      end
      GO: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // A flush seen while frozen is remembered and kills the s1 instruction on release.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_s2_q   <= NOP;
      instr_s3_q   <= NOP;
      flush_pend_q <= 1'b0;
    end else if (!stall) begin
      instr_s3_q   <= instr_s2_q;
      instr_s2_q   <= (flush || flush_pend_q) ? NOP : instr_s1;
      flush_pend_q <= 1'b0;
    end else if (flush) begin
      flush_pend_q <= 1'b1;
    end
  end

  assign instr_s2 = instr_s2_q;
  assign instr_s3 = instr_s3_q;

endmodule
